// File: rtl/vec_pkg.sv
// Shared definitions for the vector reduction pipeline: op encoding,
// tag width and the per-op identity element used to neutralise masked-off lanes.
package vec_pkg;

   localparam int TAG_W = 4;

   typedef enum logic [2:0] {
      RED_SUM = 3'd0,
      RED_MAX = 3'd1,
      RED_MIN = 3'd2,
      RED_AND = 3'd3,
      RED_OR  = 3'd4
   } redOp_e;

   // Returned at 64 bits; callers keep the low 'width' bits. Reserved ops yield 0.
   function automatic logic [63:0] identity(input logic [2:0] op, input int width);
      logic [63:0] id;
      id = '0;
      case (op)
         RED_MAX: id = 64'd1 << (width - 1);
         RED_MIN: id = (64'd1 << (width - 1)) - 64'd1;
         RED_AND: id = '1;
         default: id = '0;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/vec_reduce_pipe_node.sv
// One combinational pair combiner of the reduction tree. SUM wraps and reports
// signed overflow; reserved ops produce zero so the whole tree collapses to 0.
module red_node
   import vec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);

   logic [WIDTH-1:0] sum;

   assign sum = a + b;

   // Overflow only when both addends share a sign that the wrapped sum lost.
   always_comb begin
      y   = '0;
      ovf = 1'b0;
      case (op)
         RED_SUM: begin
            y   = sum;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         RED_MAX: y = ($signed(a) > $signed(b)) ? a : b;
         RED_MIN: y = ($signed(a) < $signed(b)) ? a : b;
         RED_AND: y = a & b;
         RED_OR:  y = a | b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vec_reduce_pipe.sv
// Pipelined masked reduction of LANES signed elements (SUM/MAX/MIN/AND/OR).
// Stage 0 registers identity-substituted operands, each later stage halves the vector.
module vec_reduce_pipe
   import vec_pkg::*;
#(
   parameter int LANES = 16,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_vec,
   input  logic [LANES-1:0]       in_mask,
   input  logic [2:0]             in_op,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_result,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_empty,
   output logic                   out_ovf,
   output logic                   out_err
);

   // The accepting edge loads stage 0, so the result lands LAT edges later counting that one.
   localparam int LAT    = $clog2(LANES) + 1;
   localparam int STAGES = LAT - 1;

   logic             stall;
   logic [WIDTH-1:0] idVal;

   // The whole pipe freezes on a stalled output; bubbles are never squeezed out.
   assign stall    = lvl[STAGES].valid & ~out_ready;
   assign in_ready = ~stall;
   assign idVal    = WIDTH'(identity(in_op, WIDTH));

   for (genvar s = 0; s <= STAGES; s++) begin : lvl
      localparam int N = LANES >> s;

      logic [WIDTH-1:0] data [N];
      logic             valid;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic             empty;
      logic             ovf;

      if (s == 0) begin : load
         // Masked-off lanes take the op identity so they cannot influence the result.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < N; k++) data[k] <= '0;
               valid <= 1'b0;
               op    <= '0;
               tag   <= '0;
               empty <= 1'b0;
               ovf   <= 1'b0;
            end else if (!stall) begin
               for (int k = 0; k < N; k++)
                  data[k] <= in_mask[k] ? in_vec[k*WIDTH +: WIDTH] : idVal;
               valid <= in_valid;
               op    <= in_op;
               tag   <= in_tag;
               empty <= ~|in_mask;
               ovf   <= 1'b0;
            end
         end
      end else begin : tree
         logic [WIDTH-1:0] y [N];
         logic [N-1:0]     nodeOvf;

         for (genvar i = 0; i < N; i++) begin : node
            red_node #(.WIDTH(WIDTH)) uNode (
               .a   (lvl[s-1].data[2*i]),
               .b   (lvl[s-1].data[2*i+1]),
               .op  (lvl[s-1].op),
               .y   (y[i]),
               .ovf (nodeOvf[i])
            );
         end

         // Sticky overflow accumulates over every node the vector passes through.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < N; k++) data[k] <= '0;
               valid <= 1'b0;
               op    <= '0;
               tag   <= '0;
               empty <= 1'b0;
               ovf   <= 1'b0;
            end else if (!stall) begin
               for (int k = 0; k < N; k++) data[k] <= y[k];
               valid <= lvl[s-1].valid;
               op    <= lvl[s-1].op;
               tag   <= lvl[s-1].tag;
               empty <= lvl[s-1].empty;
               ovf   <= lvl[s-1].ovf | (|nodeOvf);
            end
         end
      end
   end

   // The error flag is decoded from the op carried in the final register, so it travels with the data.
   assign out_valid  = lvl[STAGES].valid;
   assign out_result = lvl[STAGES].data[0];
   assign out_tag    = lvl[STAGES].tag;
   assign out_empty  = lvl[STAGES].empty;
   assign out_ovf    = lvl[STAGES].ovf;
   assign out_err    = lvl[STAGES].op > RED_OR;

endmodule

// File: tb/tb_vec_reduce_pipe.sv
// Self-checking bench for vec_reduce_pipe: directed scenarios on a 16x32 instance
// plus a randomized sweep of 2/4/64-lane instances at WIDTH=16 against a reference model.
module tb_vec_reduce_pipe;

   typedef longint laneArr_t [64];
   typedef struct {
      logic [63:0] res;
      logic        empty;
      logic        ovf;
      logic        err;
   } expect_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [511:0] inVec = '0;
   logic [15:0]  inMask = '0;
   logic [2:0]   inOp = '0;
   logic [3:0]   inTag = '0;
   logic         outValid;
   logic         outReady = 1'b1;
   logic [31:0]  outResult;
   logic [3:0]   outTag;
   logic         outEmpty;
   logic         outOvf;
   logic         outErr;

   logic [1023:0] swVec = '0;
   logic [63:0]   swMask = '0;
   logic          swValid = 1'b0;
   logic [2:0]    swOp = '0;
   logic [3:0]    swTag = '0;
   logic [2:0]    swInReady;
   logic [2:0]    swOutValid;
   logic [15:0]   swOutResult [3];
   logic [3:0]    swOutTag [3];
   logic [2:0]    swOutEmpty;
   logic [2:0]    swOutOvf;
   logic [2:0]    swOutErr;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   vec_reduce_pipe #(.LANES(16), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_vec(inVec),
      .in_mask(inMask), .in_op(inOp), .in_tag(inTag), .out_valid(outValid),
      .out_ready(outReady), .out_result(outResult), .out_tag(outTag),
      .out_empty(outEmpty), .out_ovf(outOvf), .out_err(outErr)
   );

   vec_reduce_pipe #(.LANES(2), .WIDTH(16)) dut2 (
      .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(swInReady[0]), .in_vec(swVec[31:0]),
      .in_mask(swMask[1:0]), .in_op(swOp), .in_tag(swTag), .out_valid(swOutValid[0]),
      .out_ready(1'b1), .out_result(swOutResult[0]), .out_tag(swOutTag[0]),
      .out_empty(swOutEmpty[0]), .out_ovf(swOutOvf[0]), .out_err(swOutErr[0])
   );

   vec_reduce_pipe #(.LANES(4), .WIDTH(16)) dut4 (
      .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(swInReady[1]), .in_vec(swVec[63:0]),
      .in_mask(swMask[3:0]), .in_op(swOp), .in_tag(swTag), .out_valid(swOutValid[1]),
      .out_ready(1'b1), .out_result(swOutResult[1]), .out_tag(swOutTag[1]),
      .out_empty(swOutEmpty[1]), .out_ovf(swOutOvf[1]), .out_err(swOutErr[1])
   );

   vec_reduce_pipe #(.LANES(64), .WIDTH(16)) dut64 (
      .clk(clk), .rst(rst), .in_valid(swValid), .in_ready(swInReady[2]), .in_vec(swVec),
      .in_mask(swMask), .in_op(swOp), .in_tag(swTag), .out_valid(swOutValid[2]),
      .out_ready(1'b1), .out_result(swOutResult[2]), .out_tag(swOutTag[2]),
      .out_empty(swOutEmpty[2]), .out_ovf(swOutOvf[2]), .out_err(swOutErr[2])
   );

   function automatic longint sext(input longint x, input int w);
      longint r;
      r = x & ((longint'(1) <<< w) - 1);
      if (((r >>> (w - 1)) & 1) != 0) r = r - (longint'(1) <<< w);
      return r;
   endfunction

   function automatic laneArr_t toLanes(input logic [1023:0] bits, input int w);
      laneArr_t a;
      for (int i = 0; i < 64; i++) a[i] = sext(longint'(bits >> (i * w)), w);
      return a;
   endfunction

   // Reference: reductions over participating lanes with plain integer arithmetic;
   // overflow is any pairwise partial sum leaving the signed w-bit range.
   function automatic expect_t refModel(input laneArr_t v, input logic [63:0] m,
                                        input int op, input int n, input int w);
      expect_t e;
      longint hi, lo, acc;
      longint node [64];
      bit any;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      any = 1'b0;
      e.res = '0; e.empty = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
      for (int i = 0; i < n; i++) if (m[i]) any = 1'b1;
      e.empty = !any;
      acc = 0;
      case (op)
         0: begin
            for (int i = 0; i < n; i++) node[i] = m[i] ? v[i] : 0;
            for (int len = n; len > 1; len = len / 2)
               for (int j = 0; j < len / 2; j++) begin
                  acc = node[2*j] + node[2*j+1];
                  if (acc > hi || acc < lo) e.ovf = 1'b1;
                  node[j] = sext(acc, w);
               end
            acc = node[0];
         end
         1: begin acc = lo; for (int i = 0; i < n; i++) if (m[i] && v[i] > acc) acc = v[i]; end
         2: begin acc = hi; for (int i = 0; i < n; i++) if (m[i] && v[i] < acc) acc = v[i]; end
         3: begin acc = -1; for (int i = 0; i < n; i++) if (m[i]) acc = acc & v[i]; end
         4: begin acc = 0;  for (int i = 0; i < n; i++) if (m[i]) acc = acc | v[i]; end
         default: begin acc = 0; e.err = 1'b1; end
      endcase
      e.res = 64'(acc) & ((64'd1 << w) - 64'd1);
      return e;
   endfunction

   // Drives one vector on the main DUT and waits for its result; lat counts edges from acceptance.
   task automatic applyStimulus(input logic [511:0] v, input logic [15:0] m, input logic [2:0] op,
                                input logic [3:0] tag, output int lat, output bit timedOut);
      inVec = v; inMask = m; inOp = op; inTag = tag; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      timedOut = !outValid;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      checkCount++;
      if (outValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", outValid);
      else passCount++;
      checkCount++;
      if ({outResult, outTag, outEmpty, outOvf, outErr} !== 39'd0)
         $display("[TB] FAIL reset_outputs: got res=%h tag=%h e=%b o=%b r=%b expected all 0",
                  outResult, outTag, outEmpty, outOvf, outErr);
      else passCount++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkCount++;
      if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady);
      else passCount++;
   endtask

   task automatic test_sum_full;
      logic [511:0] v;
      int lat;
      bit to;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(i + 1);
      applyStimulus(v, 16'hFFFF, 3'd0, 4'hA, lat, to);
      checkCount++;
      if (to || lat != 5) $display("[TB] FAIL sum_full_latency: got %0d (timeout=%0b) expected 5", lat, to);
      else passCount++;
      checkCount++;
      if ({outResult, outTag, outEmpty, outOvf, outErr} !== {32'd136, 4'hA, 3'b000})
         $display("[TB] FAIL sum_full_result: got res=%0d tag=%h e=%b o=%b r=%b expected 136 tag=a e=0 o=0 r=0",
                  outResult, outTag, outEmpty, outOvf, outErr);
      else passCount++;
      @(negedge clk);
   endtask

   task automatic test_sum_ovf;
      logic [511:0] v;
      int lat;
      bit to;
      v = '0;
      v[31:0]  = 32'h7FFF_FFFF;
      v[63:32] = 32'h0000_0001;
      applyStimulus(v, 16'hFFFF, 3'd0, 4'h3, lat, to);
      checkCount++;
      if (to || outResult !== 32'h8000_0000 || outOvf !== 1'b1)
         $display("[TB] FAIL sum_ovf: got res=%h ovf=%b (timeout=%0b) expected 80000000 ovf=1", outResult, outOvf, to);
      else passCount++;
      @(negedge clk);
   endtask

   task automatic test_max_min;
      logic [511:0] v;
      int lat;
      bit to;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'd100;
      v[4*32 +: 32] = -32'sd3;
      v[5*32 +: 32] = 32'sd9;
      v[6*32 +: 32] = -32'sd20;
      v[7*32 +: 32] = 32'sd2;
      applyStimulus(v, 16'h00F0, 3'd1, 4'h5, lat, to);
      checkCount++;
      if (to || outResult !== 32'd9 || outOvf !== 1'b0 || outEmpty !== 1'b0)
         $display("[TB] FAIL max_masked: got res=%0d ovf=%b e=%b expected 9 ovf=0 e=0", $signed(outResult), outOvf, outEmpty);
      else passCount++;
      @(negedge clk);
      applyStimulus(v, 16'h00F0, 3'd2, 4'h6, lat, to);
      checkCount++;
      if (to || outResult !== 32'hFFFF_FFEC || outTag !== 4'h6)
         $display("[TB] FAIL min_masked: got res=%0d tag=%h expected -20 tag=6", $signed(outResult), outTag);
      else passCount++;
      @(negedge clk);
   endtask

   task automatic test_empty;
      logic [511:0] v;
      logic [15:0] m;
      int lat;
      bit to;
      expect_t e;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      applyStimulus(v, 16'h0000, 3'd0, 4'h1, lat, to);
      checkCount++;
      if (to || outResult !== 32'd0 || outEmpty !== 1'b1)
         $display("[TB] FAIL empty_sum: got res=%h e=%b expected 0 e=1", outResult, outEmpty);
      else passCount++;
      @(negedge clk);
      applyStimulus(v, 16'h0000, 3'd1, 4'h2, lat, to);
      checkCount++;
      if (to || outResult !== 32'h8000_0000 || outEmpty !== 1'b1)
         $display("[TB] FAIL empty_max: got res=%h e=%b expected 80000000 e=1", outResult, outEmpty);
      else passCount++;
      @(negedge clk);
      applyStimulus(v, 16'hFFFF, 3'd6, 4'h7, lat, to);
      checkCount++;
      if (to || lat != 5 || outErr !== 1'b1 || outResult !== 32'd0 || outOvf !== 1'b0)
         $display("[TB] FAIL reserved_op: got lat=%0d err=%b res=%h ovf=%b expected lat=5 err=1 res=0 ovf=0",
                  lat, outErr, outResult, outOvf);
      else passCount++;
      @(negedge clk);
      m = 16'($urandom) | 16'h0001;
      e = refModel(toLanes({512'd0, v}, 32), 64'(m), 0, 16, 32);
      applyStimulus(v, m, 3'd0, 4'h8, lat, to);
      checkCount++;
      if (to || {outResult, outOvf, outErr} !== {e.res[31:0], e.ovf, 1'b0})
         $display("[TB] FAIL sum_after_reserved: got res=%h ovf=%b err=%b expected res=%h ovf=%b err=0",
                  outResult, outOvf, outErr, e.res[31:0], e.ovf);
      else passCount++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      expect_t expQ [$];
      logic [3:0] tagQ [$];
      expect_t e;
      logic [3:0] et;
      logic [511:0] v;
      logic [15:0] m;
      logic [2:0] op;
      logic [3:0] tg;
      logic [38:0] held;
      bit haveVec, prevStall;
      int sent, got, cyc;
      haveVec = 1'b0; prevStall = 1'b0; sent = 0; got = 0; cyc = 0; held = '0;
      while ((sent < 20 || expQ.size() > 0) && cyc < 400) begin
         outReady = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (!haveVec && sent < 20) begin
            for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
            m  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            op = 3'($urandom_range(0, 4));
            tg = 4'($urandom);
            haveVec = 1'b1;
         end
         inValid = haveVec; inVec = v; inMask = m; inOp = op; inTag = tg;
         #1;
         checkCount++;
         if (inReady !== !(outValid && !outReady))
            $display("[TB] FAIL stream_in_ready: cyc %0d got %b expected %b", cyc, inReady, !(outValid && !outReady));
         else passCount++;
         if (prevStall) begin
            checkCount++;
            if (outValid !== 1'b1 || {outResult, outTag, outEmpty, outOvf, outErr} !== held)
               $display("[TB] FAIL stream_hold: cyc %0d got v=%b %h expected v=1 %h", cyc, outValid,
                        {outResult, outTag, outEmpty, outOvf, outErr}, held);
            else passCount++;
         end
         if (outValid && outReady) begin
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL stream_extra: cyc %0d got res=%h with nothing expected", cyc, outResult);
            else begin
               e = expQ.pop_front();
               et = tagQ.pop_front();
               if ({outResult, outTag, outEmpty, outOvf, outErr} !== {e.res[31:0], et, e.empty, e.ovf, e.err})
                  $display("[TB] FAIL stream_result: item %0d got %h expected %h", got,
                           {outResult, outTag, outEmpty, outOvf, outErr}, {e.res[31:0], et, e.empty, e.ovf, e.err});
               else passCount++;
            end
            got++;
         end
         prevStall = outValid && !outReady;
         if (prevStall) held = {outResult, outTag, outEmpty, outOvf, outErr};
         if (inValid && inReady) begin
            expQ.push_back(refModel(toLanes({512'd0, v}, 32), 64'(m), int'(op), 16, 32));
            tagQ.push_back(tg);
            sent++;
            haveVec = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      checkCount++;
      if (sent != 20 || got != 20)
         $display("[TB] FAIL stream_count: got sent=%0d received=%0d expected 20/20 (cycles %0d)", sent, got, cyc);
      else passCount++;
   endtask

   task automatic test_reset_midflight;
      logic [511:0] v;
      logic [15:0] m;
      int lat, seen;
      bit to;
      expect_t e;
      outReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
         inVec = v; inMask = 16'hFFFF; inOp = 3'd0; inTag = 4'(k + 1); inValid = 1'b1;
         @(negedge clk);
      end
      inValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkCount++;
      if (outValid !== 1'b1) $display("[TB] FAIL midreset_pre_valid: got %b expected 1", outValid);
      else passCount++;
      #2 rst = 1'b0;
      #1;
      checkCount++;
      if (outValid !== 1'b0 || outResult !== 32'd0)
         $display("[TB] FAIL midreset_drop: got v=%b res=%h expected v=0 res=0", outValid, outResult);
      else passCount++;
      @(negedge clk);
      rst = 1'b1;
      outReady = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (outValid) seen++;
      end
      checkCount++;
      if (seen != 0) $display("[TB] FAIL midreset_ghosts: got %0d results expected 0", seen);
      else passCount++;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      m = 16'($urandom);
      e = refModel(toLanes({512'd0, v}, 32), 64'(m), 0, 16, 32);
      applyStimulus(v, m, 3'd0, 4'hC, lat, to);
      checkCount++;
      if (to || lat != 5 || {outResult, outTag, outOvf} !== {e.res[31:0], 4'hC, e.ovf})
         $display("[TB] FAIL midreset_next: got lat=%0d res=%h tag=%h ovf=%b expected lat=5 res=%h tag=c ovf=%b",
                  lat, outResult, outTag, outOvf, e.res[31:0], e.ovf);
      else passCount++;
      @(negedge clk);
   endtask

   task automatic test_param_sweep;
      int lanesA [3];
      int latA [3];
      expect_t e [3];
      lanesA = '{2, 4, 64};
      latA   = '{2, 3, 7};
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 32; k++) swVec[k*32 +: 32] = $urandom;
         swMask = (it == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (it == 1) ? 64'd0 : {32'($urandom), 32'($urandom)};
         swOp   = (it == 7) ? 3'd5 : 3'($urandom_range(0, 4));
         swTag  = 4'($urandom);
         for (int d = 0; d < 3; d++)
            e[d] = refModel(toLanes(swVec, 16), swMask, int'(swOp), lanesA[d], 16);
         checkCount++;
         if (swInReady !== 3'b111) $display("[TB] FAIL sweep_in_ready: got %b expected 111", swInReady);
         else passCount++;
         swValid = 1'b1;
         @(negedge clk);
         swValid = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            for (int d = 0; d < 3; d++) begin
               if (k == latA[d] - 1) begin
                  checkCount++;
                  if (swOutValid[d] !== 1'b0)
                     $display("[TB] FAIL sweep_early_L%0d: got valid=%b at edge %0d expected 0", lanesA[d], swOutValid[d], k);
                  else passCount++;
               end
               if (k == latA[d]) begin
                  checkCount++;
                  if ({swOutValid[d], swOutResult[d], swOutTag[d], swOutEmpty[d], swOutOvf[d], swOutErr[d]} !==
                      {1'b1, e[d].res[15:0], swTag, e[d].empty, e[d].ovf, e[d].err})
                     $display("[TB] FAIL sweep_result_L%0d: op %0d got v=%b res=%h tag=%h e=%b o=%b r=%b expected v=1 res=%h tag=%h e=%b o=%b r=%b",
                              lanesA[d], swOp, swOutValid[d], swOutResult[d], swOutTag[d], swOutEmpty[d], swOutOvf[d],
                              swOutErr[d], e[d].res[15:0], swTag, e[d].empty, e[d].ovf, e[d].err);
                  else passCount++;
               end
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting vec_reduce_pipe bench");
      test_reset();
      test_sum_full();
      test_sum_ovf();
      test_max_min();
      test_empty();
      test_back_to_back();
      test_reset_midflight();
      test_param_sweep();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
